// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: ROM address/data, decode handshake and execute redirect.
// master = fetch unit, slave = the ROM/decode/execute side.
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 30
);
    logic [ADDR_WIDTH-1:0]  oRomAddress;
    logic [INSTR_WIDTH-1:0] iRomInstruction;
    logic [INSTR_WIDTH-1:0] oInstruction;
    logic [ADDR_WIDTH-1:0]  oPC;
    logic                   oValid;
    logic                   iStall;
    logic                   iRedirect;
    logic [ADDR_WIDTH-1:0]  iRedirectAddress;
    logic                   oHalted;

    modport master (
        output oRomAddress, oInstruction, oPC, oValid, oHalted,
        input  iRomInstruction, iStall, iRedirect, iRedirectAddress
    );

    modport slave (
        input  oRomAddress, oInstruction, oPC, oValid, oHalted,
        output iRomInstruction, iStall, iRedirect, iRedirectAddress
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives ROM address from the PC, registers word+PC for decode.
// Optional macro IFU_SELF_LOOP_HALT_EN: park on a terminal "JMP to self".
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    INSTR_WIDTH  = 30,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'd0,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 30'd0,
    parameter logic [5:0]            JMP_OPCODE   = 6'd0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    instruction_fetch_unit_if.master  bus
);
`ifdef IFU_SELF_LOOP_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  opc_q, opc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic                   self_loop;

    // A JMP whose 8-bit target field equals the low PC bits of its own fetch address.
    assign self_loop = (bus.iRomInstruction[29:24] == JMP_OPCODE) &&
                       (bus.iRomInstruction[23:16] == pc_q[7:0]);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opc_d    = opc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.iRedirect) begin
                    pc_d    = bus.iRedirectAddress;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                end else if (!(bus.iStall && valid_q)) begin
                    instr_d = bus.iRomInstruction;
                    opc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 1'b1;
                    if (HALT_EN && self_loop) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                        pc_d     = pc_q;
                    end
                end
            end
            HALTED: begin
                if (bus.iRedirect) begin
                    state_d  = RUN;
                    pc_d     = bus.iRedirectAddress;
                    valid_d  = 1'b0;
                    instr_d  = NOP_WORD;
                    halted_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            opc_q    <= '0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opc_q    <= opc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.oRomAddress  = pc_q;
    assign bus.oInstruction = instr_q;
    assign bus.oPC          = opc_q;
    assign bus.oValid       = valid_q;
    assign bus.oHalted      = halted_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational ROM model.
module tb_instruction_fetch_unit;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    instruction_fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(30)) bus ();

    instruction_fetch_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    always #5 Clock = ~Clock;

    // ROM: word 16 is "JMP 16" (opcode 0), every other word is opcode 2A tagged with its address.
    function automatic logic [29:0] rom(input logic [15:0] a);
        if (a == 16'd16) return {6'd0, 8'd16, 16'd0};
        return {6'h2A, 8'h5C, a};
    endfunction

    always_comb bus.iRomInstruction = rom(bus.oRomAddress);

    localparam logic [29:0] W_A   = 30'h2A5C_0000;
    localparam logic [29:0] W_B   = 30'h2A5C_0001;
    localparam logic [29:0] W_C   = 30'h2A5C_0002;
    localparam logic [29:0] W_D   = 30'h2A5C_0003;
    localparam logic [29:0] W_45  = 30'h2A5C_002D;
    localparam logic [29:0] W_200 = 30'h2A5C_00C8;
    localparam logic [29:0] W_FFF = 30'h2A5C_FFFF;
    localparam logic [29:0] W_J16 = 30'h0010_0000;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [29:0] ins, input logic [15:0] pc);
        chk({tag, ".valid"}, 32'(bus.oValid), 32'(v));
        chk({tag, ".instr"}, 32'(bus.oInstruction), 32'(ins));
        chk({tag, ".pc"},    32'(bus.oPC), 32'(pc));
    endtask

    initial begin
        bus.iStall = 1'b0;
        bus.iRedirect = 1'b0;
        bus.iRedirectAddress = 16'd0;

        // reset state
        tick(); tick();
        chk_out("reset", 1'b0, 30'd0, 16'd0);
        chk("reset.halted", 32'(bus.oHalted), 32'd0);
        chk("reset.romaddr", 32'(bus.oRomAddress), 32'd0);

        // BOOT bubble then A, B
        Reset = 1'b1;
        tick(); chk("boot.valid", 32'(bus.oValid), 32'd0);
        tick(); chk_out("fetchA", 1'b1, W_A, 16'd0);
        tick(); chk_out("fetchB", 1'b1, W_B, 16'd1);

        // stall holding B three cycles
        bus.iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stallB", 1'b1, W_B, 16'd1);
            chk("stallB.romaddr", 32'(bus.oRomAddress), 32'd2);
        end
        bus.iStall = 1'b0;
        tick(); chk_out("fetchC", 1'b1, W_C, 16'd2);
        tick(); chk_out("fetchD", 1'b1, W_D, 16'd3);
        chk("fetchD.romaddr", 32'(bus.oRomAddress), 32'd4);

        // redirect wins over stall; bubble filled even with stall high
        bus.iStall = 1'b1; bus.iRedirect = 1'b1; bus.iRedirectAddress = 16'd45;
        tick(); chk_out("redir.bubble", 1'b0, 30'd0, 16'd3);
        bus.iRedirect = 1'b0;
        tick(); chk_out("redir.target", 1'b1, W_45, 16'd45);
        tick(); chk_out("redir.stallhold", 1'b1, W_45, 16'd45);
        bus.iStall = 1'b0;

        // back-to-back redirects: last wins
        bus.iRedirect = 1'b1; bus.iRedirectAddress = 16'd100;
        tick();
        bus.iRedirectAddress = 16'd200;
        tick(); chk("b2b.valid", 32'(bus.oValid), 32'd0);
        bus.iRedirect = 1'b0;
        tick(); chk_out("b2b.target", 1'b1, W_200, 16'd200);

        // PC wrap
        bus.iRedirect = 1'b1; bus.iRedirectAddress = 16'hFFFF;
        tick();
        bus.iRedirect = 1'b0;
        tick(); chk_out("wrap.ffff", 1'b1, W_FFF, 16'hFFFF);
        tick(); chk_out("wrap.0000", 1'b1, W_A, 16'h0000);

        // reset during stall
        bus.iStall = 1'b1;
        tick(); chk_out("prerst.hold", 1'b1, W_A, 16'h0000);
        Reset = 1'b0;
        tick(); chk_out("midrst", 1'b0, 30'd0, 16'd0);
        chk("midrst.romaddr", 32'(bus.oRomAddress), 32'd0);
        bus.iStall = 1'b0;
        Reset = 1'b1;
        tick(); chk("reboot.valid", 32'(bus.oValid), 32'd0);
        tick(); chk_out("reboot.A", 1'b1, W_A, 16'd0);

        // self-loop at 16
        bus.iRedirect = 1'b1; bus.iRedirectAddress = 16'd16;
        tick();
        bus.iRedirect = 1'b0;
        tick(); chk_out("jmp16", 1'b1, W_J16, 16'd16);
`ifdef IFU_SELF_LOOP_HALT_EN
        chk("halt.flag", 32'(bus.oHalted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_out("halt.hold", 1'b1, W_J16, 16'd16);
            chk("halt.romaddr", 32'(bus.oRomAddress), 32'd16);
            chk("halt.flaghold", 32'(bus.oHalted), 32'd1);
        end
        bus.iRedirect = 1'b1; bus.iRedirectAddress = 16'd3;
        tick(); chk("unhalt.flag", 32'(bus.oHalted), 32'd0);
        chk("unhalt.valid", 32'(bus.oValid), 32'd0);
        bus.iRedirect = 1'b0;
        tick(); chk_out("unhalt.D", 1'b1, W_D, 16'd3);
`else
        chk("nohalt.flag", 32'(bus.oHalted), 32'd0);
        chk("nohalt.romaddr", 32'(bus.oRomAddress), 32'd17);
        tick(); chk("nohalt.pc17", 32'(bus.oPC), 32'd17);
        chk("nohalt.flag2", 32'(bus.oHalted), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage between the program ROM and the CPU decode/execute logic.
- Drives the ROM address and registers the returned 30-bit instruction word with its PC.
- Presents the instruction to decode with a valid/stall handshake.
- Redirects the PC on JMP/CALL/RET/branch resolution from execute.

Parameters:
ADDR_WIDTH, 16, PC and ROM address width
INSTR_WIDTH, 30, instruction word width
RESET_VECTOR, 16'd0, first fetch address after reset
NOP_WORD, 30'd0, value of oInstruction while invalid/reset
JMP_OPCODE, 6'd0, opcode field value (bits [29:24]) of JMP; used only by the optional feature

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-low reset
oRomAddress  output  ADDR_WIDTH  address to ROM (combinational from PC register)
iRomInstruction  input  INSTR_WIDTH  ROM data, combinational same-cycle response to oRomAddress
oInstruction  output  INSTR_WIDTH  registered instruction to decode
oPC  output  ADDR_WIDTH  address oInstruction was fetched from
oValid  output  1  oInstruction/oPC hold a real instruction
iStall  input  1  decode cannot accept; hold outputs
iRedirect  input  1  one-cycle pulse: discard in-flight fetch, jump
iRedirectAddress  input  ADDR_WIDTH  target PC, sampled when iRedirect=1
oHalted  output  1  fetch stopped on self-loop (tied 0 without the optional feature)

Behaviour:
- Reset=0 at a clock edge: rPC=RESET_VECTOR, state=BOOT, oValid=0, oInstruction=NOP_WORD, oPC=0, oHalted=0. Overrides everything, including mid-stall and mid-redirect.
- oRomAddress = rPC at all times. There is no ROM latency beyond the combinational path.
- States: BOOT, RUN, HALTED.
- BOOT: lasts exactly one cycle after reset release. oValid=0. Next state is RUN, rPC unchanged, so the first instruction (at RESET_VECTOR) is valid in the 2nd cycle after Reset rises.
- RUN, priority order per edge:
  1. iRedirect=1: rPC<=iRedirectAddress, oValid<=0, oInstruction<=NOP_WORD. Wins over iStall. Exactly one bubble cycle; the target is valid on the following edge.
  2. iStall=1 and oValid=1: hold rPC, oInstruction, oPC, oValid.
  3. Otherwise (including iStall=1 with oValid=0, i.e. the bubble is filled): oInstruction<=iRomInstruction, oPC<=rPC, oValid<=1, rPC<=rPC+1.
- Throughput: one instruction per cycle with no stall or redirect.
- PC arithmetic is modulo 2^ADDR_WIDTH: 16'hFFFF+1 wraps to 16'h0000 without a flag.
- An instruction is consumed by decode on any cycle with oValid=1 and iStall=0.
- iRedirect while oValid=0 (back-to-back redirects): the last one wins, bubble persists.
- HALTED: only reachable with the optional feature. Outputs are held and oValid stays 1. Leaves only on iRedirect (goes to RUN, bubble as above) or on reset.
- No X propagation: every register has a defined reset value; state encoding has a default that returns to BOOT.

Optional Feature:
- Macro: IFU_SELF_LOOP_HALT_EN.
- Defined: in RUN, when a word is loaded with iRomInstruction[29:24]==JMP_OPCODE and iRomInstruction[23:16]==rPC[7:0]:
  - state<=HALTED, oHalted<=1, rPC not incremented.
  - The self-loop instruction stays presented with oValid=1, which stops ROM toggling on a terminal "JMP to self".
  - oHalted returns to 0 on redirect or reset.
- Undefined: no halt detection. The self-jump is fetched and redirected normally via execute, and oHalted is constant 0.

Test Plan:
- Reset release, ROM[0..3]=A,B,C,D, no stall: cycle 1 oValid=0; cycles 2..5 oInstruction=A,B,C,D with oPC=0,1,2,3; oRomAddress=4 after cycle 5.
- iStall=1 for 3 cycles while oInstruction=B (oPC=1): B/oPC=1 held 3 cycles, oRomAddress stays 2; C appears on the cycle after iStall drops.
- iRedirect=1, iRedirectAddress=16'd45 concurrently with iStall=1: next cycle oValid=0, oInstruction=NOP_WORD; following cycle oInstruction=ROM[45], oPC=45.
- PC wrap: redirect to 16'hFFFF → oPC=16'hFFFF, then oPC=16'h0000 next cycle, oValid continuous.
- Reset driven 0 during a stall with oValid=1: next edge oValid=0, oPC=0, oRomAddress=RESET_VECTOR; BOOT bubble repeats after release.
- With IFU_SELF_LOOP_HALT_EN, ROM[16]={JMP_OPCODE,8'd16,16'b0}: after fetch oHalted=1, oPC=16, oRomAddress=16 constant for 20 cycles; redirect to 3 clears oHalted and fetches ROM[3]. Without the macro, oPC advances to 17.
